// File: rtl/simmem_pkg.sv
// Request/response types shared by the simulated memory controller and its ideal memory stand-in.
package simmem_pkg;

    localparam int unsigned IdWidth           = 4;
    localparam int unsigned AddrWidth         = 16;
    localparam int unsigned DataWidth         = 32;
    localparam int unsigned MaxRBurstLenWidth = 4;
    localparam int unsigned MaxWBurstLenWidth = 4;
    localparam int unsigned MaxRBurstLen      = 15;
    localparam int unsigned MaxWBurstLen      = 15;

    typedef struct packed {
        logic [IdWidth-1:0]           id;
        logic [AddrWidth-1:0]         addr;
        logic [MaxRBurstLenWidth-1:0] burst_len;
    } raddr_t;

    typedef struct packed {
        logic [IdWidth-1:0]           id;
        logic [AddrWidth-1:0]         addr;
        logic [MaxWBurstLenWidth-1:0] burst_len;
    } waddr_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic                 last;
    } wdata_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic                 last;
    } rdata_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
    } wresp_t;

endpackage

// File: rtl/simmem_ideal_mem_if.sv
// Bus bundle between the memory controller (master) and the ideal memory responder (slave).
interface simmem_ideal_mem_if;

    logic                  raddr_valid_i;
    logic                  raddr_ready_o;
    simmem_pkg::raddr_t    raddr_i;
    logic                  waddr_valid_i;
    logic                  waddr_ready_o;
    simmem_pkg::waddr_t    waddr_i;
    logic                  wdata_valid_i;
    logic                  wdata_ready_o;
    simmem_pkg::wdata_t    wdata_i;
    logic                  rdata_valid_o;
    logic                  rdata_ready_i;
    simmem_pkg::rdata_t    rdata_o;
    logic                  wresp_valid_o;
    logic                  wresp_ready_i;
    simmem_pkg::wresp_t    wresp_o;

    modport master (
        output raddr_valid_i, raddr_i, waddr_valid_i, waddr_i, wdata_valid_i, wdata_i,
               rdata_ready_i, wresp_ready_i,
        input  raddr_ready_o, waddr_ready_o, wdata_ready_o, rdata_valid_o, rdata_o,
               wresp_valid_o, wresp_o
    );

    modport slave (
        input  raddr_valid_i, raddr_i, waddr_valid_i, waddr_i, wdata_valid_i, wdata_i,
               rdata_ready_i, wresp_ready_i,
        output raddr_ready_o, waddr_ready_o, wdata_ready_o, rdata_valid_o, rdata_o,
               wresp_valid_o, wresp_o
    );

endinterface

// File: rtl/simmem_ideal_mem.sv
// Fixed-latency ideal memory: in-order read bursts and write responses after RespLatency idle cycles.
// Define SIMMEM_IDEAL_MEM_ASSERT_EN to compile in the input-protocol checker.

module simmem_ideal_mem_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW:0]      wptr_r;
    logic [PtrW:0]      rptr_r;
    logic [Width-1:0]   mem_r [Depth];
    logic               push_ok_s;
    logic               pop_ok_s;

    assign full_o    = (wptr_r[PtrW] != rptr_r[PtrW]) && (wptr_r[PtrW-1:0] == rptr_r[PtrW-1:0]);
    assign empty_o   = (wptr_r == rptr_r);
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;
    assign data_o    = mem_r[rptr_r[PtrW-1:0]];

    // Pointer update; the extra wrap bit separates full from empty.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wptr_r <= wptr_r + (PtrW+1)'(1);
            end
            if (pop_ok_s) begin
                rptr_r <= rptr_r + (PtrW+1)'(1);
            end
        end
    end

    // Entry storage; contents are meaningless while the entry is not occupied.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_r[wptr_r[PtrW-1:0]] <= data_i;
        end
    end
endmodule

`ifdef SIMMEM_IDEAL_MEM_ASSERT_EN
module simmem_ideal_mem_sva (
    input logic               clk_i,
    input logic               rst_ni,
    input logic               raddr_valid_i,
    input logic               raddr_ready_o,
    input simmem_pkg::raddr_t raddr_i,
    input logic               waddr_valid_i,
    input logic               waddr_ready_o,
    input simmem_pkg::waddr_t waddr_i,
    input logic               wdata_valid_i,
    input logic               wdata_ready_o,
    input simmem_pkg::wdata_t wdata_i,
    input logic               w_final_beat_s
);
    raddr_hold_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (raddr_valid_i && !raddr_ready_o) |=> (raddr_valid_i && $stable(raddr_i)));
    waddr_hold_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (waddr_valid_i && !waddr_ready_o) |=> (waddr_valid_i && $stable(waddr_i)));
    wdata_hold_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (wdata_valid_i && !wdata_ready_o) |=> (wdata_valid_i && $stable(wdata_i)));
    rlen_max_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        raddr_valid_i |-> (32'(raddr_i.burst_len) <= 32'(simmem_pkg::MaxRBurstLen)));
    wlen_max_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        waddr_valid_i |-> (32'(waddr_i.burst_len) <= 32'(simmem_pkg::MaxWBurstLen)));
    wlast_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (wdata_valid_i && wdata_ready_o) |-> (wdata_i.last == w_final_beat_s));
endmodule
`endif

module simmem_ideal_mem #(
    parameter int unsigned ReadQueueDepth  = 4,
    parameter int unsigned WriteQueueDepth = 4,
    parameter int unsigned RespLatency     = 3
) (
    input logic                clk_i,
    input logic                rst_ni,
    simmem_ideal_mem_if.slave  bus
);
    import simmem_pkg::*;

    localparam int unsigned RBW  = MaxRBurstLenWidth;
    localparam int unsigned WBW  = MaxWBurstLenWidth;
    localparam int unsigned LatW = (RespLatency == 0) ? 1 : $clog2(RespLatency + 1);
    localparam logic [LatW-1:0] LatLoad = LatW'(RespLatency);

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [RBW-1:0]     len;
    } rq_entry_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [WBW-1:0]     len;
    } wq_entry_t;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_BURST = 2'd2} r_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_WAIT = 2'd2, W_RESP = 2'd3} w_state_t;

    // Read path state
    r_state_t           r_state_r, r_state_next_s;
    logic [IdWidth-1:0] r_id_r, r_id_next_s;
    logic [RBW-1:0]     r_len_r, r_len_next_s;
    logic [RBW-1:0]     r_beat_r, r_beat_next_s;
    logic [LatW-1:0]    r_lat_r, r_lat_next_s;
    logic               r_pop_s, r_full_s, r_empty_s, rdata_hs_s;
    rq_entry_t          r_head_s, r_push_data_s;
    logic               rdata_valid_r, rdata_valid_next_s;
    rdata_t             rdata_r, rdata_next_s;

    // Write path state
    w_state_t           w_state_r, w_state_next_s;
    logic [IdWidth-1:0] w_id_r, w_id_next_s;
    logic [WBW-1:0]     w_len_r, w_len_next_s;
    logic [WBW-1:0]     w_beat_r, w_beat_next_s;
    logic [LatW-1:0]    w_lat_r, w_lat_next_s;
    logic               w_pop_s, w_full_s, w_empty_s, wdata_hs_s, wresp_hs_s;
    wq_entry_t          w_head_s, w_push_data_s;
    logic               wdata_ready_r, wdata_ready_next_s;
    logic               wresp_valid_r, wresp_valid_next_s;
    wresp_t             wresp_r, wresp_next_s;

    logic               unused_s;

    assign r_push_data_s = '{id: bus.raddr_i.id, len: bus.raddr_i.burst_len};
    assign w_push_data_s = '{id: bus.waddr_i.id, len: bus.waddr_i.burst_len};

    simmem_ideal_mem_fifo #(.Depth(ReadQueueDepth), .Width($bits(rq_entry_t))) u_read_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (bus.raddr_valid_i),
        .data_i  (r_push_data_s),
        .pop_i   (r_pop_s),
        .data_o  (r_head_s),
        .full_o  (r_full_s),
        .empty_o (r_empty_s)
    );

    simmem_ideal_mem_fifo #(.Depth(WriteQueueDepth), .Width($bits(wq_entry_t))) u_write_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (bus.waddr_valid_i),
        .data_i  (w_push_data_s),
        .pop_i   (w_pop_s),
        .data_o  (w_head_s),
        .full_o  (w_full_s),
        .empty_o (w_empty_s)
    );

    assign bus.raddr_ready_o = !r_full_s;
    assign bus.waddr_ready_o = !w_full_s;
    assign bus.rdata_valid_o = rdata_valid_r;
    assign bus.rdata_o       = rdata_r;
    assign bus.wdata_ready_o = wdata_ready_r;
    assign bus.wresp_valid_o = wresp_valid_r;
    assign bus.wresp_o       = wresp_r;

    assign rdata_hs_s = rdata_valid_r && bus.rdata_ready_i;
    assign wdata_hs_s = wdata_ready_r && bus.wdata_valid_i;
    assign wresp_hs_s = wresp_valid_r && bus.wresp_ready_i;
    assign unused_s   = ^{bus.raddr_i.addr, bus.waddr_i.addr, bus.wdata_i};

    // Read FSM state and active-request registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state_r <= R_IDLE;
            r_id_r    <= '0;
            r_len_r   <= '0;
            r_beat_r  <= '0;
            r_lat_r   <= '0;
        end else begin
            r_state_r <= r_state_next_s;
            r_id_r    <= r_id_next_s;
            r_len_r   <= r_len_next_s;
            r_beat_r  <= r_beat_next_s;
            r_lat_r   <= r_lat_next_s;
        end
    end

    // Read FSM next state; WAIT leaves when the counter is about to hit zero.
    always_comb begin
        r_state_next_s = r_state_r;
        r_pop_s        = 1'b0;
        r_id_next_s    = r_id_r;
        r_len_next_s   = r_len_r;
        r_beat_next_s  = r_beat_r;
        r_lat_next_s   = r_lat_r;
        case (r_state_r)
            R_IDLE: begin
                if (!r_empty_s) begin
                    r_pop_s        = 1'b1;
                    r_id_next_s    = r_head_s.id;
                    r_len_next_s   = r_head_s.len;
                    r_beat_next_s  = '0;
                    r_lat_next_s   = LatLoad;
                    r_state_next_s = (RespLatency == 0) ? R_BURST : R_WAIT;
                end else begin
                    r_state_next_s = R_IDLE;
                end
            end
            R_WAIT: begin
                r_lat_next_s = r_lat_r - LatW'(1);
                if (r_lat_r <= LatW'(1)) begin
                    r_state_next_s = R_BURST;
                end else begin
                    r_state_next_s = R_WAIT;
                end
            end
            R_BURST: begin
                if (rdata_hs_s && (r_beat_r == r_len_r)) begin
                    r_state_next_s = R_IDLE;
                end else if (rdata_hs_s) begin
                    r_beat_next_s = r_beat_r + RBW'(1);
                end else begin
                    r_state_next_s = R_BURST;
                end
            end
            default: r_state_next_s = R_IDLE;
        endcase
    end

    // Read output values for the next cycle, derived from the next active registers.
    always_comb begin
        rdata_next_s       = '0;
        rdata_valid_next_s = (r_state_next_s == R_BURST);
        if (rdata_valid_next_s) begin
            rdata_next_s.id   = r_id_next_s;
            rdata_next_s.last = (r_beat_next_s == r_len_next_s);
        end else begin
            rdata_next_s = '0;
        end
    end

    // Write FSM state and active-request registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            w_state_r <= W_IDLE;
            w_id_r    <= '0;
            w_len_r   <= '0;
            w_beat_r  <= '0;
            w_lat_r   <= '0;
        end else begin
            w_state_r <= w_state_next_s;
            w_id_r    <= w_id_next_s;
            w_len_r   <= w_len_next_s;
            w_beat_r  <= w_beat_next_s;
            w_lat_r   <= w_lat_next_s;
        end
    end

    // Write FSM next state; data is only accepted once its address is active.
    always_comb begin
        w_state_next_s = w_state_r;
        w_pop_s        = 1'b0;
        w_id_next_s    = w_id_r;
        w_len_next_s   = w_len_r;
        w_beat_next_s  = w_beat_r;
        w_lat_next_s   = w_lat_r;
        case (w_state_r)
            W_IDLE: begin
                if (!w_empty_s) begin
                    w_pop_s        = 1'b1;
                    w_id_next_s    = w_head_s.id;
                    w_len_next_s   = w_head_s.len;
                    w_beat_next_s  = '0;
                    w_state_next_s = W_DATA;
                end else begin
                    w_state_next_s = W_IDLE;
                end
            end
            W_DATA: begin
                if (wdata_hs_s && (w_beat_r == w_len_r)) begin
                    w_lat_next_s   = LatLoad;
                    w_state_next_s = (RespLatency == 0) ? W_RESP : W_WAIT;
                end else if (wdata_hs_s) begin
                    w_beat_next_s = w_beat_r + WBW'(1);
                end else begin
                    w_state_next_s = W_DATA;
                end
            end
            W_WAIT: begin
                w_lat_next_s = w_lat_r - LatW'(1);
                if (w_lat_r <= LatW'(1)) begin
                    w_state_next_s = W_RESP;
                end else begin
                    w_state_next_s = W_WAIT;
                end
            end
            W_RESP: begin
                if (wresp_hs_s) begin
                    w_state_next_s = W_IDLE;
                end else begin
                    w_state_next_s = W_RESP;
                end
            end
            default: w_state_next_s = W_IDLE;
        endcase
    end

    // Write output values for the next cycle.
    always_comb begin
        wresp_next_s       = '0;
        wdata_ready_next_s = (w_state_next_s == W_DATA);
        wresp_valid_next_s = (w_state_next_s == W_RESP);
        if (wresp_valid_next_s) begin
            wresp_next_s.id = w_id_next_s;
        end else begin
            wresp_next_s = '0;
        end
    end

    // Registered handshake outputs for both paths.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_valid_r <= 1'b0;
            rdata_r       <= '0;
            wdata_ready_r <= 1'b0;
            wresp_valid_r <= 1'b0;
            wresp_r       <= '0;
        end else begin
            rdata_valid_r <= rdata_valid_next_s;
            rdata_r       <= rdata_next_s;
            wdata_ready_r <= wdata_ready_next_s;
            wresp_valid_r <= wresp_valid_next_s;
            wresp_r       <= wresp_next_s;
        end
    end

`ifdef SIMMEM_IDEAL_MEM_ASSERT_EN
    simmem_ideal_mem_sva u_sva (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .raddr_valid_i  (bus.raddr_valid_i),
        .raddr_ready_o  (bus.raddr_ready_o),
        .raddr_i        (bus.raddr_i),
        .waddr_valid_i  (bus.waddr_valid_i),
        .waddr_ready_o  (bus.waddr_ready_o),
        .waddr_i        (bus.waddr_i),
        .wdata_valid_i  (bus.wdata_valid_i),
        .wdata_ready_o  (bus.wdata_ready_o),
        .wdata_i        (bus.wdata_i),
        .w_final_beat_s (w_beat_r == w_len_r)
    );
`else
    // Protocol checker not compiled into this build.
`endif
endmodule

// File: tb/tb_simmem_ideal_mem.sv
// Scoreboard bench for simmem_ideal_mem: expected beats/responses are queued at request acceptance.
module tb_simmem_ideal_mem;
    import simmem_pkg::*;

    localparam int unsigned RQD = 4;
    localparam int unsigned WQD = 4;
    localparam int unsigned LAT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    simmem_ideal_mem_if bus();

    simmem_ideal_mem #(.ReadQueueDepth(RQD), .WriteQueueDepth(WQD), .RespLatency(LAT)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic               last;
    } rbeat_t;

    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    int     ready_mode = 0;     // 0: readies high, 1: random, 2: low
    int     rbeats_seen = 0;
    int     wresps_seen = 0;
    int     last_rhs_cyc = 0;
    int     last_whs_cyc = 0;
    rbeat_t rq[$];
    logic [IdWidth-1:0] wq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdata_valid"}, 64'(bus.rdata_valid_o), 64'd0);
        check({tag, "_wresp_valid"}, 64'(bus.wresp_valid_o), 64'd0);
        check({tag, "_raddr_ready"}, 64'(bus.raddr_ready_o), 64'd1);
        check({tag, "_waddr_ready"}, 64'(bus.waddr_ready_o), 64'd1);
        check({tag, "_wdata_ready"}, 64'(bus.wdata_ready_o), 64'd0);
        check({tag, "_rdata_zero"},  64'(bus.rdata_o), 64'd0);
        check({tag, "_wresp_zero"},  64'(bus.wresp_o), 64'd0);
    endtask

    task automatic send_raddr(input int id, input int len);
        int n = 0;
        rbeat_t e;
        bus.raddr_i           = '0;
        bus.raddr_i.id        = IdWidth'(id);
        bus.raddr_i.burst_len = MaxRBurstLenWidth'(len);
        bus.raddr_i.addr      = AddrWidth'($urandom);
        bus.raddr_valid_i     = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.raddr_ready_o) break;
            n++;
            if (n > 200) begin
                timeout_fail("raddr_accept");
                break;
            end
        end
        if (bus.raddr_ready_o) begin
            for (int b = 0; b <= len; b++) begin
                e.id   = IdWidth'(id);
                e.last = (b == len);
                rq.push_back(e);
            end
        end
        last_rhs_cyc = cyc;
        @(posedge clk); #1;
        bus.raddr_valid_i = 1'b0;
    endtask

    task automatic send_waddr(input int id, input int len);
        int n = 0;
        bus.waddr_i           = '0;
        bus.waddr_i.id        = IdWidth'(id);
        bus.waddr_i.burst_len = MaxWBurstLenWidth'(len);
        bus.waddr_i.addr      = AddrWidth'($urandom);
        bus.waddr_valid_i     = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.waddr_ready_o) break;
            n++;
            if (n > 200) begin
                timeout_fail("waddr_accept");
                break;
            end
        end
        if (bus.waddr_ready_o) wq.push_back(IdWidth'(id));
        @(posedge clk); #1;
        bus.waddr_valid_i = 1'b0;
    endtask

    task automatic send_wbeats(input int len, input int maxgap);
        int n;
        for (int b = 0; b <= len; b++) begin
            repeat ($urandom_range(maxgap, 0)) begin
                @(posedge clk); #1;
            end
            bus.wdata_i.data  = $urandom;
            bus.wdata_i.last  = (b == len);
            bus.wdata_valid_i = 1'b1;
            n = 0;
            forever begin
                @(negedge clk);
                if (bus.wdata_ready_o) break;
                n++;
                if (n > 200) begin
                    timeout_fail("wdata_accept");
                    break;
                end
            end
            last_whs_cyc = cyc;
            @(posedge clk); #1;
            bus.wdata_valid_i = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_rq_empty"}, 64'(rq.size()), 64'd0);
        check({name, "_wq_empty"}, 64'(wq.size()), 64'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    // Response-side ready generation
    initial begin
        bus.rdata_ready_i = 1'b0;
        bus.wresp_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: begin bus.rdata_ready_i = 1'b1; bus.wresp_ready_i = 1'b1; end
                1: begin bus.rdata_ready_i = 1'($urandom); bus.wresp_ready_i = 1'($urandom); end
                default: begin bus.rdata_ready_i = 1'b0; bus.wresp_ready_i = 1'b0; end
            endcase
        end
    end

    // Monitor: pops the scoreboard on each response handshake and checks stall stability
    initial begin
        logic   prev_rv = 1'b0, prev_rr = 1'b0, prev_wv = 1'b0, prev_wr = 1'b0;
        rdata_t prev_rd = '0;
        wresp_t prev_wd = '0;
        rdata_t exp_r;
        wresp_t exp_w;
        rbeat_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_rv && !prev_rr) begin
                    check("rdata_stall_valid", 64'(bus.rdata_valid_o), 64'd1);
                    check("rdata_stall_payload", 64'(bus.rdata_o), 64'(prev_rd));
                end
                if (prev_wv && !prev_wr) begin
                    check("wresp_stall_valid", 64'(bus.wresp_valid_o), 64'd1);
                    check("wresp_stall_payload", 64'(bus.wresp_o), 64'(prev_wd));
                end
                if (bus.rdata_valid_o && bus.rdata_ready_i) begin
                    rbeats_seen++;
                    if (rq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL rdata_unexpected: got beat id %0d, expected none", bus.rdata_o.id);
                    end else begin
                        e = rq.pop_front();
                        exp_r      = '0;
                        exp_r.id   = e.id;
                        exp_r.last = e.last;
                        check("rdata_beat", 64'(bus.rdata_o), 64'(exp_r));
                    end
                end
                if (bus.wresp_valid_o && bus.wresp_ready_i) begin
                    wresps_seen++;
                    if (wq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL wresp_unexpected: got id %0d, expected none", bus.wresp_o.id);
                    end else begin
                        exp_w    = '0;
                        exp_w.id = wq.pop_front();
                        check("wresp", 64'(bus.wresp_o), 64'(exp_w));
                    end
                end
                prev_rv = bus.rdata_valid_o;
                prev_rr = bus.rdata_ready_i;
                prev_rd = bus.rdata_o;
                prev_wv = bus.wresp_valid_o;
                prev_wr = bus.wresp_ready_i;
                prev_wd = bus.wresp_o;
            end else begin
                prev_rv = 1'b0;
                prev_wv = 1'b0;
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Main stimulus
    initial begin
        int n, snap, acc, len;
        rbeat_t e;
        bus.raddr_valid_i = 1'b0;
        bus.raddr_i       = '0;
        bus.waddr_valid_i = 1'b0;
        bus.waddr_i       = '0;
        bus.wdata_valid_i = 1'b0;
        bus.wdata_i       = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Single read: 4 beats, first beat 2+LAT cycles after the handshake
        ready_mode = 0;
        snap = rbeats_seen;
        send_raddr(2, 3);
        n = 0;
        while (!bus.rdata_valid_o && n < 50) begin @(negedge clk); n++; end
        check("read_first_beat_latency", 64'(cyc - last_rhs_cyc), 64'(2 + LAT));
        wait_drain("single_read");
        check("single_read_beats", 64'(rbeats_seen - snap), 64'd4);

        // Write with gaps between data beats
        send_waddr(5, 1);
        send_wbeats(1, 3);
        n = 0;
        while (!bus.wresp_valid_o && n < 50) begin @(negedge clk); n++; end
        check("write_resp_latency", 64'(cyc - last_whs_cyc), 64'(1 + LAT));
        wait_drain("gap_write");

        // Data before address: stalled until the address is active
        bus.wdata_i.data  = $urandom;
        bus.wdata_i.last  = 1'b1;
        bus.wdata_valid_i = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("wdata_ready_before_addr", 64'(bus.wdata_ready_o), 64'd0);
        end
        @(posedge clk); #1;
        send_waddr(3, 0);
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.wdata_ready_o) break;
            n++;
            if (n > 50) begin timeout_fail("early_wdata_accept"); break; end
        end
        @(posedge clk); #1;
        bus.wdata_valid_i = 1'b0;
        wait_drain("early_wdata");

        // Read FIFO fill with the response side blocked
        ready_mode = 2;
        repeat (2) begin @(posedge clk); #1; end
        acc = 0;
        len = $urandom_range(3, 0);
        bus.raddr_i           = '0;
        bus.raddr_i.id        = IdWidth'(acc);
        bus.raddr_i.burst_len = MaxRBurstLenWidth'(len);
        bus.raddr_valid_i     = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (!bus.raddr_ready_o || n > 20) break;
            for (int b = 0; b <= len; b++) begin
                e.id   = IdWidth'(acc);
                e.last = (b == len);
                rq.push_back(e);
            end
            acc++;
            n++;
            len = $urandom_range(3, 0);
            @(posedge clk); #1;
            bus.raddr_i.id        = IdWidth'(acc);
            bus.raddr_i.burst_len = MaxRBurstLenWidth'(len);
        end
        check("rfifo_fill_accepted", 64'(acc), 64'(RQD + 1));
        ready_mode = 1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.raddr_ready_o) break;
            n++;
            if (n > 300) begin timeout_fail("rfifo_release"); break; end
        end
        for (int b = 0; b <= len; b++) begin
            e.id   = IdWidth'(acc);
            e.last = (b == len);
            rq.push_back(e);
        end
        @(posedge clk); #1;
        bus.raddr_valid_i = 1'b0;
        wait_drain("rfifo_fill");

        // Backpressure during an 8-beat burst
        ready_mode = 1;
        snap = rbeats_seen;
        send_raddr(9, 7);
        wait_drain("backpressure");
        check("backpressure_beats", 64'(rbeats_seen - snap), 64'd8);

        // Random concurrent traffic on both paths
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    send_raddr($urandom_range(15, 0), $urandom_range(7, 0));
                    repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
                end
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    len = $urandom_range(3, 0);
                    send_waddr($urandom_range(15, 0), len);
                    send_wbeats(len, 2);
                end
            end
        join
        wait_drain("random");

        // Reset while beat 2 of a burst is presented
        ready_mode = 0;
        repeat (2) begin @(posedge clk); #1; end
        snap = rbeats_seen;
        send_raddr(6, 7);
        n = 0;
        while (rbeats_seen < snap + 2 && n < 50) begin @(posedge clk); #1; n++; end
        rst_n = 1'b0;
        rq.delete();
        wq.delete();
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midburst_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        snap = rbeats_seen;
        repeat (30) begin @(posedge clk); #1; end
        check("no_resp_after_reset", 64'(rbeats_seen - snap), 64'd0);
        check("no_valid_after_reset", 64'(bus.rdata_valid_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
